// File: rtl/jk_drv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : jk_drv_pkg
//  Purpose : Shared FSM encoding and the per-bit JK excitation function.
//  Rev     : 1.0  initial release
// ============================================================================
package jk_drv_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Returns {j,k} moving a flop from q to t; don't-care legs take toggle_x.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic toggle_x);
        logic [1:0] r;
        r = 2'b00;
        case ({q, t})
            2'b00:   r = {1'b0, toggle_x};
            2'b01:   r = {1'b1, toggle_x};
            2'b10:   r = {toggle_x, 1'b1};
            2'b11:   r = {toggle_x, 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excite_vec.sv
`default_nettype none
// ============================================================================
//  Module  : jk_excite_vec
//  Purpose : WIDTH-wide combinational J/K excitation from current Q to target.
//  Rev     : 1.0  initial release
// ============================================================================
module jk_excite_vec
    import jk_drv_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TOGGLE_X = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    localparam logic c_X = (TOGGLE_X != 0);

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [1:0] w_jk;
        assign w_jk  = jk_excite(q[gi], t[gi], c_X);
        assign j[gi] = w_jk[1];
        assign k[gi] = w_jk[0];
    end

endmodule
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
//  Module  : jk_bank_driver
//  Purpose : Drives J/K excitation into a JK flop bank to reach a target word,
//            verifies Q after settling and retries a bounded number of times.
//  Rev     : 1.0  initial release
// ============================================================================
module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3,
    parameter int TOGGLE_X  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int                  c_HOLD_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [c_HOLD_W-1:0] c_SETTLE    = c_HOLD_W'(SETTLE);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(1);
    localparam logic [3:0]          c_MAX_RETRY = 4'(MAX_RETRY);

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_tgt;
    logic [3:0]          r_retry;
    logic [c_HOLD_W-1:0] r_hold;

    logic [WIDTH-1:0]    w_exc_tgt;
    logic [WIDTH-1:0]    w_j;
    logic [WIDTH-1:0]    w_k;
    logic                w_match;
    logic                w_retry_ok;
    logic                w_accept;
    logic                w_redrive;
    logic                w_load_jk;

    // Excitation uses the incoming word on accept and the latched one on retry.
    assign w_exc_tgt  = (r_state == ST_IDLE) ? tgt_data : r_tgt;
    assign w_match    = (q_fb == r_tgt);
    assign w_retry_ok = (r_retry < c_MAX_RETRY);

    jk_excite_vec #(
        .WIDTH    (WIDTH),
        .TOGGLE_X (TOGGLE_X)
    ) u_excite (
        .q (q_fb),
        .t (w_exc_tgt),
        .j (w_j),
        .k (w_k)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (tgt_valid) w_next = ST_DRIVE;
            ST_DRIVE: w_next = ST_HOLD;
            ST_HOLD:  if (r_hold == c_HOLD_LAST) w_next = ST_CHECK;
            ST_CHECK: w_next = (!w_match && w_retry_ok) ? ST_DRIVE : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tgt_ready = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        w_accept  = (r_state == ST_IDLE) && tgt_valid;
        w_redrive = (r_state == ST_CHECK) && !w_match && w_retry_ok;
        w_load_jk = w_accept || w_redrive;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j       <= '0;
            k       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            r_tgt   <= '0;
            r_retry <= '0;
            r_hold  <= '0;
        end else begin
            // J/K are live only for the single cycle following a load.
            j    <= w_load_jk ? w_j : '0;
            k    <= w_load_jk ? w_k : '0;
            done <= (r_state == ST_CHECK) && w_match;
            err  <= (r_state == ST_CHECK) && !w_match && !w_retry_ok;

            if (w_accept) begin
                r_tgt   <= tgt_data;
                r_retry <= '0;
            end else if (w_redrive) begin
                r_retry <= r_retry + 4'd1;
            end

            if (r_state == ST_DRIVE) begin
                r_hold <= c_SETTLE;
            end else if (r_state == ST_HOLD) begin
                r_hold <= r_hold - c_HOLD_LAST;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
//  Module  : tb_jk_bank_driver
//  Purpose : Scoreboard bench for jk_bank_driver driving a modelled JK bank.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_jk_bank_driver;

    localparam int SETTLE = 2;
    localparam int PER_ATTEMPT = 2 + SETTLE;

    typedef struct {
        logic       is_err;
        logic [3:0] q;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tgt_valid [2];
    logic [3:0] tgt_data  [2];
    logic       tgt_ready [2];
    logic [3:0] q_fb      [2];
    logic [3:0] j         [2];
    logic [3:0] k         [2];
    logic       busy      [2];
    logic       done      [2];
    logic       err       [2];
    logic       bank_load [2];
    logic [3:0] bank_val  [2];
    logic [3:0] stuck     [2];

    int   n_pass;
    int   n_total;
    int   cyc;
    int   pulses;
    bit   count_en;
    exp_t sb0[$];
    exp_t sb1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 uses TOGGLE_X=0, instance 1 uses TOGGLE_X=1; each drives its own bank.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_dut
        logic [3:0] bq;

        jk_bank_driver #(
            .WIDTH     (4),
            .SETTLE    (SETTLE),
            .MAX_RETRY (3),
            .TOGGLE_X  (gi)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tgt_valid (tgt_valid[gi]),
            .tgt_data  (tgt_data[gi]),
            .tgt_ready (tgt_ready[gi]),
            .q_fb      (q_fb[gi]),
            .j         (j[gi]),
            .k         (k[gi]),
            .busy      (busy[gi]),
            .done      (done[gi]),
            .err       (err[gi])
        );

        always @(posedge clk) begin
            if (bank_load[gi]) bq <= bank_val[gi];
            else               bq <= (j[gi] & ~bq) | (~k[gi] & bq);
        end

        assign q_fb[gi] = bq & ~stuck[gi];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (count_en && j[0] != 4'd0) pulses++;
        for (int d = 0; d < 2; d++) begin
            if (done[d] || err[d]) begin
                have = 1'b0;
                if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                check("resp_expected", {31'd0, have}, 32'd1);
                check("done_err_excl", {31'd0, done[d] & err[d]}, 32'd0);
                if (have) begin
                    check("resp_kind_err", {31'd0, err[d]}, {31'd0, e.is_err});
                    check("resp_q_fb", {28'd0, q_fb[d]}, {28'd0, e.q});
                    check("resp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic preload(input int d, input logic [3:0] v);
        @(negedge clk);
        bank_load[d] = 1'b1;
        bank_val[d]  = v;
        @(negedge clk);
        bank_load[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [3:0] t, input logic [3:0] ej, input logic [3:0] ek,
                        input bit push, input bit is_err, input logic [3:0] eq, input int attempts,
                        input bit keep, output int acc);
        exp_t e;
        int   w;
        w   = 0;
        acc = -1;
        @(negedge clk);
        tgt_valid[d] = 1'b1;
        tgt_data[d]  = t;
        while (!tgt_ready[d] && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!tgt_ready[d]) begin
            check("accept_timeout", 32'd0, 32'd1);
            tgt_valid[d] = 1'b0;
            return;
        end
        if (push) begin
            e.is_err = is_err;
            e.q      = eq;
            e.cyc    = cyc + 1 + PER_ATTEMPT * attempts;
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        check("drive_j", {28'd0, j[d]}, {28'd0, ej});
        check("drive_k", {28'd0, k[d]}, {28'd0, ek});
        check("drive_busy", {31'd0, busy[d]}, 32'd1);
        check("drive_ready", {31'd0, tgt_ready[d]}, 32'd0);
        if (!keep) tgt_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int w;
        w = 0;
        @(negedge clk);
        while (busy[d] && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("idle_timeout", {31'd0, busy[d]}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc_a;
        int acc_b;
        n_pass   = 0;
        n_total  = 0;
        pulses   = 0;
        count_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tgt_valid[d] = 1'b0;
            tgt_data[d]  = 4'd0;
            bank_load[d] = 1'b1;
            bank_val[d]  = 4'd0;
            stuck[d]     = 4'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_j", {28'd0, j[0]}, 32'd0);
        check("rst_k", {28'd0, k[0]}, 32'd0);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_ready", {31'd0, tgt_ready[0]}, 32'd1);
        check("rst_done_err", {30'd0, done[0], err[0]}, 32'd0);
        bank_load[0] = 1'b0;
        bank_load[1] = 1'b0;
        rst = 1'b0;

        // 0000 -> 1010, set/reset style
        preload(0, 4'b0000);
        send(0, 4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0, 4'b1010, 1, 1'b0, acc_a);
        @(posedge clk);
        #1;
        check("hold_j", {28'd0, j[0]}, 32'd0);
        check("hold_k", {28'd0, k[0]}, 32'd0);
        wait_idle(0);

        // target already present: hold excitation, still completes
        preload(0, 4'b0101);
        send(0, 4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0101, 1, 1'b0, acc_a);
        wait_idle(0);

        // bit0 stuck low: four drive attempts then err
        preload(0, 4'b0000);
        stuck[0] = 4'b0001;
        pulses   = 0;
        count_en = 1'b1;
        send(0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0000, 4, 1'b0, acc_a);
        wait_idle(0);
        count_en = 1'b0;
        check("retry_pulses", pulses, 32'd4);
        stuck[0] = 4'b0000;

        // back-to-back with valid held; bank now holds 0001
        send(0, 4'b0011, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0011, 1, 1'b1, acc_a);
        send(0, 4'b1100, 4'b1100, 4'b0011, 1'b1, 1'b0, 4'b1100, 1, 1'b0, acc_b);
        check("b2b_accept_cycle", acc_b, acc_a + PER_ATTEMPT + 1);
        wait_idle(0);

        // toggle style: 1100 -> 0110
        preload(1, 4'b1100);
        send(1, 4'b0110, 4'b1110, 4'b1011, 1'b1, 1'b0, 4'b0110, 1, 1'b0, acc_a);
        wait_idle(1);

        // async reset while in HOLD abandons the transaction silently
        preload(0, 4'b0000);
        send(0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1, 1'b0, acc_a);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_j", {28'd0, j[0]}, 32'd0);
        check("midrst_k", {28'd0, k[0]}, 32'd0);
        check("midrst_busy", {31'd0, busy[0]}, 32'd0);
        check("midrst_ready", {31'd0, tgt_ready[0]}, 32'd1);
        check("midrst_done_err", {30'd0, done[0], err[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        check("sb0_drained", sb0.size(), 32'd0);
        check("sb1_drained", sb1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
